// File: rtl/deck_shuffler.sv
// Card deck shuffler: one-cycle identity init, then an LFSR-driven Fisher-Yates pass with
// rejection of out-of-range candidates, then sequential draw from the top of the deck.
module deck_shuffler #(
    parameter int unsigned          DECK_SIZE = 108,
    parameter int unsigned          LFSR_W    = 8,
    parameter logic [LFSR_W-1:0]    LFSR_TAPS = 8'hB8,
    localparam int unsigned         IDX_W     = $clog2(DECK_SIZE),
    localparam int unsigned         CNT_W     = $clog2(DECK_SIZE + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_draw,
    output logic [IDX_W-1:0] o_card,
    output logic             o_card_valid,
    output logic [CNT_W-1:0] o_remaining,
    output logic             o_empty,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {StIdle, StInit, StShuffle, StReady} state_e;

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  seed_q, seed_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [IDX_W-1:0]   end_q, end_d;
    logic [IDX_W-1:0]   top_q, top_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   deck_q [DECK_SIZE];
    logic [IDX_W-1:0]   deck_d [DECK_SIZE];

    logic [LFSR_W-1:0]  lfsr_next;
    logic [IDX_W-1:0]   cand;

    assign lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign cand      = lfsr_q[IDX_W-1:0];

    assign o_card       = deck_q[top_q];
    assign o_card_valid = (state_q == StReady) && (rem_q != '0);
    assign o_remaining  = rem_q;
    assign o_empty      = (state_q == StReady) && (rem_q == '0);
    assign o_busy       = (state_q == StInit) || (state_q == StShuffle);
    assign o_done       = done_q;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        end_d   = end_q;
        top_d   = top_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        deck_d  = deck_q;

        unique case (state_q)
            StIdle: begin
                seed_d = seed_q + LFSR_W'(1);
                if (i_start) begin
                    // A zero seed would lock the LFSR, so substitute 1.
                    lfsr_d  = (seed_q == '0) ? LFSR_W'(1) : seed_q;
                    state_d = StInit;
                end
            end
            StInit: begin
                for (int unsigned i = 0; i < DECK_SIZE; i++) begin
                    deck_d[i] = IDX_W'(i);
                end
                end_d   = IDX_W'(DECK_SIZE - 1);
                rem_d   = '0;
                top_d   = '0;
                state_d = StShuffle;
            end
            StShuffle: begin
                if (i_start) begin
                    state_d = StInit;
                end else begin
                    lfsr_d = lfsr_next;
                    if (cand <= end_q) begin
                        deck_d[cand]  = deck_q[end_q];
                        deck_d[end_q] = deck_q[cand];
                        end_d         = end_q - IDX_W'(1);
                        if (end_q == IDX_W'(1)) begin
                            state_d = StReady;
                            top_d   = '0;
                            rem_d   = CNT_W'(DECK_SIZE);
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            StReady: begin
                if (i_start) begin
                    state_d = StInit;
                end else if (i_draw && o_card_valid) begin
                    rem_d = rem_q - CNT_W'(1);
                    // Top stays on the last card once the deck is exhausted.
                    if (top_q != IDX_W'(DECK_SIZE - 1)) begin
                        top_d = top_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            seed_q  <= '0;
            lfsr_q  <= LFSR_W'(1);
            end_q   <= '0;
            top_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < DECK_SIZE; i++) begin
                deck_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            end_q   <= end_d;
            top_q   <= top_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            deck_q  <= deck_d;
        end
    end

endmodule
